// File: rtl/video_term.sv
// video_term: scrolling teletype text terminal rendered from an 8x8 glyph font.
// Define VIDEO_TERM_CURSOR_EN to add a blinking cursor over the write position.
module video_term #(
  parameter int COLS         = 32,
  parameter int ROWS         = 32,
  parameter int START_ROW    = 28,
  parameter int READY_HPOS   = 256,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  hpos,
  input  logic [8:0]  vpos,
  input  logic        te,
  input  logic [7:0]  ti,
  output logic        tready,
  output logic [10:0] glyph_addr,
  input  logic [7:0]  glyph_data,
  output logic        dot
);

  // state    | meaning
  // S_CLEAR  | zeroing the whole buffer, cnt walks every cell
  // S_IDLE   | accepting characters from the CPU
  // S_SCROLL | zeroing the new cursor row, cnt walks its columns
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = CW + RW;

  localparam logic [1:0] S_CLEAR  = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_SCROLL = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] top_row_q, top_row_d;
  logic [RW-1:0] cur_row_q, cur_row_d;
  logic [CW-1:0] cur_col_q, cur_col_d;

  logic [7:0]    char_q, char_d;
  logic [2:0]    line_q, line_d;
  logic [2:0]    pix_q, pix_d;
  logic          blank_q, blank_d;
  logic          dot_q, dot_d;

  logic [7:0]    mem [COLS*ROWS];
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [7:0]    c;
  logic [CW-1:0] col_dec;

  logic [RW-1:0] scr_row, buf_row;
  logic [CW-1:0] scr_col;
  logic [AW-1:0] rd_addr;
  logic          invert;

  assign c       = ti & 8'h7F;
  assign col_dec = cur_col_q - 1'b1;
  assign tready  = (state_q == S_IDLE) && !te && (hpos == 9'(READY_HPOS));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    top_row_d = top_row_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    we        = 1'b0;
    waddr     = '0;
    wdata     = 8'h00;
    case (state_q)
      S_CLEAR: begin
        we    = 1'b1;
        waddr = cnt_q;
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = S_IDLE;
      end
      S_SCROLL: begin
        we    = 1'b1;
        waddr = {cur_row_q, cnt_q[CW-1:0]};
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q[CW-1:0]) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        if (te) begin
          if (c == 8'h0D) begin
            cur_col_d = '0;
            cur_row_d = cur_row_q + 1'b1;
            top_row_d = top_row_q + 1'b1;
            cnt_d     = '0;
            state_d   = S_SCROLL;
          end else if (c == 8'h08) begin
            if (cur_col_q != '0) begin
              cur_col_d = col_dec;
              we        = 1'b1;
              waddr     = {cur_row_q, col_dec};
              wdata     = 8'h20;
            end
          end else if (c == 8'h0C) begin
            top_row_d = '0;
            cur_row_d = RW'(START_ROW);
            cur_col_d = '0;
            cnt_d     = '0;
            state_d   = S_CLEAR;
          end else if (c >= 8'h20 && c <= 8'h7E) begin
            we    = 1'b1;
            waddr = {cur_row_q, cur_col_q};
            wdata = c;
            // Last column wraps: the write and the newline share one cycle.
            if (&cur_col_q) begin
              cur_col_d = '0;
              cur_row_d = cur_row_q + 1'b1;
              top_row_d = top_row_q + 1'b1;
              cnt_d     = '0;
              state_d   = S_SCROLL;
            end else begin
              cur_col_d = cur_col_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign scr_row = vpos[3 +: RW];
  assign scr_col = hpos[3 +: CW];
  assign buf_row = scr_row + top_row_q;
  assign rd_addr = {buf_row, scr_col};

  // Read happens before the same-edge write lands, so video sees the old cell.
  always_comb begin
    char_d  = mem[rd_addr];
    line_d  = vpos[2:0];
    pix_d   = hpos[2:0];
    blank_d = (hpos >= 9'(COLS*8)) || (vpos >= 9'(ROWS*8));
    dot_d   = blank_q ? 1'b0 : (glyph_data[~pix_q] ^ invert);
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      cnt_q     <= '0;
      top_row_q <= '0;
      cur_row_q <= RW'(START_ROW);
      cur_col_q <= '0;
      char_q    <= 8'h00;
      line_q    <= 3'd0;
      pix_q     <= 3'd0;
      blank_q   <= 1'b1;
      dot_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      top_row_q <= top_row_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      char_q    <= char_d;
      line_q    <= line_d;
      pix_q     <= pix_d;
      blank_q   <= blank_d;
      dot_q     <= dot_d;
    end
  end

  assign glyph_addr = {char_q, line_q};
  assign dot        = dot_q;

`ifdef VIDEO_TERM_CURSOR_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;
  logic          cursor_q, cursor_d;

  always_comb begin
    frame_d  = frame_q;
    phase_d  = phase_q;
    if (hpos == 9'd0 && vpos == 9'd0) begin
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
    cursor_d = (buf_row == cur_row_q) && (scr_col == cur_col_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q  <= '0;
      phase_q  <= 1'b0;
      cursor_q <= 1'b0;
    end else begin
      frame_q  <= frame_d;
      phase_q  <= phase_d;
      cursor_q <= cursor_d;
    end
  end

  assign invert = cursor_q & phase_q;
`else
  assign invert = 1'b0;
`endif

endmodule

// File: tb/tb_video_term.sv
// Directed bench for video_term: beam positions are driven directly so any cell can be probed.
module tb_video_term;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [8:0]  hpos = 9'd256;
  logic [8:0]  vpos = 9'd0;
  logic        te = 1'b0;
  logic [7:0]  ti = 8'h00;
  logic        tready;
  logic [10:0] glyph_addr;
  logic [7:0]  glyph_data;
  logic        dot;

  int n_checks = 0;
  int n_fail   = 0;

  video_term #(.BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .te         (te),
    .ti         (ti),
    .tready     (tready),
    .glyph_addr (glyph_addr),
    .glyph_data (glyph_data),
    .dot        (dot)
  );

  always #5 clk = ~clk;

  // Character 0 is blank; every other glyph row is char + line.
  function automatic logic [7:0] font(input logic [10:0] a);
    if (a[10:3] == 8'h00) return 8'h00;
    return a[10:3] + {5'b0, a[2:0]};
  endfunction

  assign glyph_data = font(glyph_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ch);
    int n;
    n = 0;
    te   = 1'b0;
    hpos = 9'd256;
    #1;
    while (!tready && n < 3000) begin
      step();
      n++;
    end
    check("send_ready", tready, 1);
    ti = ch;
    te = 1'b1;
    step();
    te = 1'b0;
  endtask

  task automatic busy_len(input string tag, input int exp, input bit poke);
    int n;
    n = 0;
    hpos = 9'd256;
    while (!tready && n < 3000) begin
      te = poke && (n == 4);
      ti = 8'h5A;
      step();
      n++;
    end
    te = 1'b0;
    check(tag, n, exp);
  endtask

  task automatic check_cell(input string tag, input int r, input int col, input logic [7:0] exp);
    vpos = 9'(r*8 + 3);
    hpos = 9'(col*8 + 2);
    step();
    check(tag, glyph_addr, {exp, 3'd3});
  endtask

  task automatic dot_at(input string tag, input int h, input int v, input logic exp);
    hpos = 9'(h);
    vpos = 9'(v);
    step();
    step();
    check(tag, dot, exp);
  endtask

  task automatic scan_row(input int r, input logic [7:0] c0, input logic [7:0] c1);
    logic [7:0] ch;
    logic [7:0] g;
    for (int h = 0; h < 18; h++) begin
      hpos = 9'(h);
      vpos = 9'(r*8);
      step();
      if (h > 0) begin
        ch = ((h-1) < 8) ? c0 : c1;
        g  = font({ch, 3'd0});
        check("dot_scan", dot, g[7 - ((h-1) % 8)]);
      end
    end
  endtask

  initial begin
    logic any_dot;

    #1 reset = 1'b1;
    step();
    step();
    check("rst_tready", tready, 0);
    check("rst_dot", dot, 0);
    check("rst_glyph", glyph_addr, 0);
    reset = 1'b0;
    busy_len("reset_clear_len", 1024, 1'b0);

    hpos = 9'd255; #1;
    check("tready_255", tready, 0);
    hpos = 9'd257; #1;
    check("tready_257", tready, 0);
    hpos = 9'd256; te = 1'b1; ti = 8'h00; #1;
    check("tready_te", tready, 0);
    te = 1'b0; #1;
    check("tready_256", tready, 1);

    any_dot = 1'b0;
    for (int v = 0; v < 300; v += 23) begin
      for (int h = 0; h < 300; h++) begin
        hpos = 9'(h);
        vpos = 9'(v);
        step();
        any_dot |= dot;
      end
    end
    check("frame_blank", any_dot, 0);

    send(8'h41);
    check_cell("a_cell", 28, 0, 8'h41);
    scan_row(28, 8'h41, 8'h00);
    dot_at("vis", 1, 224, 1'b1);
    dot_at("blank_h", 257, 224, 1'b0);
    dot_at("blank_v", 1, 480, 1'b0);
    send(8'h42);
    check_cell("col1", 28, 1, 8'h42);

    send(8'h0D);
    busy_len("cr_busy", 32, 1'b1);
    check_cell("cr_up_a", 27, 0, 8'h41);
    check_cell("cr_up_b", 27, 1, 8'h42);
    check_cell("cr_clr0", 28, 0, 8'h00);
    check_cell("cr_clr1", 28, 1, 8'h00);
    send(8'h43);
    check_cell("after_cr", 28, 0, 8'h43);

    send(8'h0D);
    busy_len("cr2_busy", 32, 1'b0);
    for (int i = 0; i < 32; i++) send(8'h58);
    busy_len("wrap_busy", 32, 1'b0);
    check_cell("wrap_c0", 27, 0, 8'h58);
    check_cell("wrap_c15", 27, 15, 8'h58);
    check_cell("wrap_c31", 27, 31, 8'h58);
    check_cell("wrap_prev", 26, 0, 8'h43);
    check_cell("wrap_clr", 28, 0, 8'h00);
    send(8'h59);
    check_cell("wrap_col0", 28, 0, 8'h59);

    send(8'h0D);
    busy_len("cr3_busy", 32, 1'b0);
    send(8'h08);
    send(8'h4B);
    check_cell("bs_col0", 28, 0, 8'h4B);
    check_cell("bs_col0_c31", 28, 31, 8'h00);
    send(8'h4C);
    send(8'h4D);
    send(8'h4E);
    send(8'h4F);
    send(8'h08);
    check_cell("bs_space", 28, 4, 8'h20);
    check_cell("bs_keep", 28, 3, 8'h4E);
    send(8'h50);
    check_cell("bs_then_p", 28, 4, 8'h50);
    send(8'h7F);
    send(8'h01);
    check_cell("ignored", 28, 5, 8'h00);
    send(8'h52);
    check_cell("after_ign", 28, 5, 8'h52);
    send(8'hC1);
    check_cell("bit7", 28, 6, 8'h41);

    send(8'h0C);
    busy_len("ff_busy", 1024, 1'b0);
    check_cell("ff_clr_y", 31, 0, 8'h00);
    check_cell("ff_clr_k", 0, 0, 8'h00);
    send(8'h53);
    check_cell("ff_home", 28, 0, 8'h53);

    send(8'h0C);
    repeat (500) step();
    reset = 1'b1;
    step();
    check("midrst_tready", tready, 0);
    check("midrst_glyph", glyph_addr, 0);
    reset = 1'b0;
    busy_len("rst_mid_clear", 1024, 1'b0);
    check_cell("midrst_clr", 28, 0, 8'h00);
    send(8'h54);
    check_cell("midrst_home", 28, 0, 8'h54);

`ifdef VIDEO_TERM_CURSOR_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    busy_len("cur_clear", 1024, 1'b0);
    for (int f = 0; f < 6; f++) begin
      dot_at("blink", 2, 224, (f == 2 || f == 3));
      hpos = 9'd0;
      vpos = 9'd0;
      step();
    end
    hpos = 9'd0;
    vpos = 9'd0;
    step();
    dot_at("blink_on", 2, 224, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    busy_len("cur_clear2", 1024, 1'b0);
    dot_at("blink_rst", 2, 224, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
